// File: rtl/result_buffer.sv
// result_buffer: small output-side FIFO for results from the calculate stage.
// A downstream consumer drains entries through a valid/ready handshake:
// a read happens on any rising edge where out_valid=1 and out_ready=1.
// A write happens on any rising edge where in_valid=1, provided there is room
// (or a read in the same cycle frees a slot). A write that finds the buffer
// full with no read is dropped. Each drop sets the sticky overflow flag and
// increments drop_count, which saturates at 255.
// Optional feature macro: RESULT_BUFFER_STATS_EN adds the max_result and
// result_sum statistics outputs.
module result_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    input  logic                       clr_ovf
`ifdef RESULT_BUFFER_STATS_EN
    ,
    output logic [WIDTH-1:0]           max_result,
    output logic [WIDTH+7:0]           result_sum
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic is_empty;
    logic is_full;
    logic do_read;
    logic do_write;
    logic do_drop;

    // Handshake qualification: a read frees a slot, so a full buffer can
    // still accept a write in the same cycle as a read.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
        do_read  = !is_empty && out_ready;
        do_write = in_valid && (!is_full || do_read);
        do_drop  = in_valid && is_full && !do_read;
    end

    // Next-state for pointers, occupancy and drop bookkeeping.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;

        if (do_write && !do_read)      count_d = count_q + 1'b1;
        else if (do_read && !do_write) count_d = count_q - 1'b1;

        // A drop in the same cycle as a clear wins: the clear happens first,
        // and then this drop is recorded as the first one.
        if (clr_ovf) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
        if (do_drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)                      drop_count_d = 8'd1;
            else if (drop_count_q != 8'd255)  drop_count_d = drop_count_q + 8'd1;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage array. It is not reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_ptr_q] <= in_data;
    end

    // Outputs are derived from registered state only. There is no fall-through.
    always_comb begin
        out_valid  = !is_empty;
        out_data   = is_empty ? '0 : mem_q[rd_ptr_q];
        count      = count_q;
        full       = is_full;
        overflow   = overflow_q;
        drop_count = drop_count_q;
    end

`ifdef RESULT_BUFFER_STATS_EN
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH+7:0] sum_q, sum_d;
    logic [WIDTH+8:0] sum_ext;

    // Statistics next-state. These update on accepted writes only;
    // the sum saturates at all-ones.
    always_comb begin
        max_d   = max_q;
        sum_d   = sum_q;
        sum_ext = {1'b0, sum_q} + (WIDTH+9)'(in_data);
        if (do_write) begin
            if (in_data > max_q) max_d = in_data;
            sum_d = sum_ext[WIDTH+8] ? '1 : sum_ext[WIDTH+7:0];
        end
    end

    // Statistics registers. clr_ovf deliberately leaves them alone.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            sum_q <= '0;
        end else begin
            max_q <= max_d;
            sum_q <= sum_d;
        end
    end

    assign max_result = max_q;
    assign result_sum = sum_q;
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Directed testbench for result_buffer with hand-computed expectations.
module tb_result_buffer;

  logic       clock;
  logic       rst;
  logic [4:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       out_valid;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       clr_ovf;
`ifdef RESULT_BUFFER_STATS_EN
  logic [4:0]  max_result;
  logic [12:0] result_sum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  result_buffer #(.DEPTH(4), .WIDTH(5)) dut (
    .clock      (clock),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_ovf    (clr_ovf)
`ifdef RESULT_BUFFER_STATS_EN
    ,
    .max_result (max_result),
    .result_sum (result_sum)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"},  32'(out_data), 0);
    check({tag, "_full"},  32'(full), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_drops"}, 32'(drop_count), 0);
  endtask

  task automatic write_one(input logic [4:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    check_zero("rst_async");
    step(); step();
    rst = 1'b0;
    step();
    check_zero("idle");

    // three writes, then drain in order
    write_one(5'd3);
    check("w1_count", 32'(count), 1);
    check("w1_data", 32'(out_data), 3);
    write_one(5'd17);
    write_one(5'd30);
    check("w3_count", 32'(count), 3);
    check("w3_valid", 32'(out_valid), 1);
    check("head3", 32'(out_data), 3);
    out_ready = 1'b1;
    step();
    check("head17", 32'(out_data), 17);
    check("cnt2", 32'(count), 2);
    step();
    check("head30", 32'(out_data), 30);
    check("cnt1", 32'(count), 1);
    step();
    check("cnt0", 32'(count), 0);
    check("empty_data", 32'(out_data), 0);
    check("empty_valid", 32'(out_valid), 0);

    // out_ready on an empty buffer is ignored
    step();
    check("empty_rd_cnt", 32'(count), 0);

    // simultaneous write and read when empty: only the write happens
    in_valid = 1'b1; in_data = 5'd5;
    step();
    in_valid = 1'b0;
    check("wr_rd_empty_cnt", 32'(count), 1);
    check("wr_rd_empty_data", 32'(out_data), 5);
    step();
    check("wr_rd_empty_drain", 32'(count), 0);
    out_ready = 1'b0;

    // fill, then two dropped writes
    for (int i = 0; i < 4; i++) write_one(5'(10 + i));
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    check("fill_ovf", 32'(overflow), 0);
    write_one(5'd9);
    write_one(5'd9);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_cnt", 32'(drop_count), 2);
    check("drop_count_held", 32'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_after_drop", 32'(out_data), 32'(10 + i));
      step();
    end
    check("drain_empty", 32'(count), 0);
    out_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_drops", 32'(drop_count), 0);

    // full buffer with simultaneous read and write: pointer wrap
    for (int i = 1; i <= 4; i++) begin
      write_one(5'(i));
      exp_q.push_back(5'(i));
    end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 5'(20 + i);
      check("wrap_head", 32'(out_data), 32'(exp_q.pop_front()));
      exp_q.push_back(5'(20 + i));
      step();
      check("wrap_count", 32'(count), 4);
      check("wrap_drops", 32'(drop_count), 0);
    end
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      check("wrap_drain", 32'(out_data), 32'(exp_q.pop_front()));
      step();
    end
    check("wrap_empty", 32'(count), 0);
    check("wrap_ovf", 32'(overflow), 0);
    out_ready = 1'b0;

    // 300 drops saturate drop_count at 255
    for (int i = 0; i < 4; i++) write_one(5'(i));
    in_valid = 1'b1; in_data = 5'd7;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    check("sat_drops", 32'(drop_count), 255);
    check("sat_ovf", 32'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("sat_clr_ovf", 32'(overflow), 0);
    check("sat_clr_drops", 32'(drop_count), 0);
    clr_ovf = 1'b1; in_valid = 1'b1;
    step();
    clr_ovf = 1'b0; in_valid = 1'b0;
    check("clr_drop_ovf", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_count), 1);

    // asynchronous reset with three entries held
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_rst_count", 32'(count), 3);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    step();
    rst = 1'b0;
    step();
    check_zero("post_rst");

`ifdef RESULT_BUFFER_STATS_EN
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_one(5'd31);
    check("stats_max", 32'(max_result), 31);
    check("stats_sum", 32'(result_sum), 93);
    in_valid = 1'b1; in_data = 5'd31;
    for (int i = 0; i < 270; i++) step();
    in_valid = 1'b0;
    check("stats_sat", 32'(result_sum), 32'h1FFF);
    out_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_buffer.md
# result_buffer

Output-side buffer that consumes the 5-bit result and its valid strobe from the four-operand capture/calculate stage and holds results in a small FIFO. A downstream consumer drains results at its own pace with a valid/ready handshake. Results that arrive while the buffer is full are dropped, counted, and flagged.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- WIDTH, 5, result width; matches the calculate stage output

Ports:
- clock  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  result from the calculate stage
- in_valid  in  1  write strobe; each cycle high is one write request
- out_ready  in  1  consumer accepts head entry this cycle
- out_data  out  WIDTH  head entry; 0 when empty
- out_valid  out  1  buffer non-empty
- count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- overflow  out  1  sticky; set when a write is dropped
- drop_count  out  8  dropped writes, saturates at 255
- clr_ovf  in  1  synchronous pulse; clears overflow and drop_count

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 → 0. Separate count register; full/empty derive from count only.
- Write: in_valid=1 and (count<DEPTH, or count==DEPTH with read this cycle) → mem[wr_ptr] ← in_data, wr_ptr+1.
- Read: out_valid=1 and out_ready=1 → rd_ptr+1. out_data is mem[rd_ptr] when count>0, else 0.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Drop: in_valid=1, count==DEPTH, no read → no write, overflow←1, drop_count+1 (held at 255).
- clr_ovf=1: overflow←0, drop_count←0. A drop in the same cycle takes priority: overflow=1, drop_count=1.
- out_ready with empty buffer is ignored; pointers and count unchanged.
- Reset (any time, including mid-transfer): pointers, count, overflow, drop_count ← 0; out_valid=0, out_data=0, full=0. Array contents need not be cleared.

## Timing
- No fall-through. A write at edge N makes out_valid=1 and out_data valid after edge N, so the first read completes no earlier than edge N+1.
- Read at edge N: next entry, or empty indication, appears after edge N.
- Simultaneous write and read when empty: only the write occurs; out_valid was 0.
- Simultaneous write and read when full: both occur, count stays DEPTH, no drop.
- full, count, and overflow are registered and reflect state after the last edge.
- Throughput: one write and one read per cycle sustained.
- Reset is asynchronous: outputs reach reset values while rst=1 without waiting for a clock edge. Reset release is synchronous to the next clock edge.

## Configuration
- RESULT_BUFFER_STATS_EN defined: adds two outputs.
  - max_result[WIDTH-1:0]: largest value ever written, reset 0.
  - result_sum[WIDTH+7:0]: sum of all accepted writes, saturating at all-ones, reset 0.
  - Both update only on accepted writes, not drops. clr_ovf does not affect them.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: count=0, out_valid=0, out_data=0, full=0, overflow=0, drop_count=0; assert rst mid-stream with 3 entries → all outputs zero immediately.
- Write 5'd3, 5'd17, 5'd30 with out_ready=0, then hold out_ready=1 → out_data reads 3, 17, 30 on consecutive cycles; count goes 3→2→1→0.
- Fill 4 entries, then write 5'd9 twice with out_ready=0 → full=1, overflow=1, drop_count=2; drain yields only the original 4 values.
- Full buffer with in_valid=1 and out_ready=1 every cycle for 8 cycles → count stays 4, no drops, output is in-order continuation; pointers wrap cleanly.
- Force 300 drops → drop_count saturates at 255; clr_ovf pulse → overflow=0, drop_count=0; clr_ovf coinciding with a drop → overflow=1, drop_count=1.
- With RESULT_BUFFER_STATS_EN, write 31, 31, 31 → max_result=31, result_sum=93; drive enough 31s to saturate → result_sum=13'h1FFF.
